// File: rtl/calc_pkg.sv
// Shared constants for the calc datapath and its result buffer.
package calc_pkg;

   localparam int Q_DWIDTH     = 32;
   localparam int RESBUF_DEPTH = 8;

   // Width of an occupancy count that can represent 0..depth inclusive.
   function automatic int resbuf_lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/calc_resbuf_fifo.sv
// Synchronous show-ahead FIFO holding calc results; push/pop are pre-qualified
// by the caller, so this block never sees a push while full without a pop.
module calc_resbuf_fifo
   import calc_pkg::*;
#(
   parameter int WIDTH = Q_DWIDTH,
   parameter int DEPTH = RESBUF_DEPTH,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             srst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;

   // Storage has no reset; stale words are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= din;
      end
   end

   // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (srst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   assign dout = mem[rptr];

endmodule

// File: rtl/calc_result_buf.sv
// Result buffer behind calc: stores results, tracks in-flight work and gates
// upstream issue. Optional push counter port when CALC_RESBUF_CNT_EN is defined.
module calc_result_buf
   import calc_pkg::*;
#(
   parameter int DEPTH = RESBUF_DEPTH,
   parameter int Q_W   = Q_DWIDTH
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     calc_tvalid_i,
   input  logic                     res_tvalid_i,
   input  logic [Q_W-1:0]           res_q_i,
   output logic                     issue_ok_o,
   output logic                     m_tvalid_o,
   output logic [Q_W-1:0]           m_tdata_o,
   input  logic                     m_tready_i,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
`ifdef CALC_RESBUF_CNT_EN
   ,
   output logic [31:0]              res_cnt_o
`endif
);

   localparam int LVL_W = resbuf_lvl_w(DEPTH);
   localparam int CNT_W = LVL_W + 1;
   localparam int SUM_W = CNT_W + 1;
   localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
   localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

   logic [LVL_W-1:0] level;
   logic [CNT_W-1:0] inflight;
   logic             push;
   logic             pop;
   logic             full;

   // Downstream handshake: a beat transfers on a rising edge where
   // m_tvalid_o and m_tready_i are both high; m_tdata_o holds until then.
   assign full = (level == DEPTH_L);
   assign pop  = m_tvalid_o & m_tready_i & ~srst;
   assign push = res_tvalid_i & ~srst & (~full | pop);

   calc_resbuf_fifo #(
      .WIDTH (Q_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .srst  (srst),
      .push  (push),
      .pop   (pop),
      .din   (res_q_i),
      .dout  (m_tdata_o),
      .level (level)
   );

   assign level_o    = level;
   assign m_tvalid_o = (level != '0);

   // Counter saturates at both ends so a misbehaving upstream cannot wrap it.
   always_ff @(posedge clk) begin
      if (srst) begin
         inflight <= '0;
      end else if (calc_tvalid_i && !res_tvalid_i && (inflight != '1)) begin
         inflight <= inflight + 1'b1;
      end else if (!calc_tvalid_i && res_tvalid_i && (inflight != '0)) begin
         inflight <= inflight - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         overflow_o <= 1'b0;
      end else if (res_tvalid_i && !push) begin
         overflow_o <= 1'b1;
      end
   end

   assign issue_ok_o = ~srst & ((SUM_W'(level) + SUM_W'(inflight)) < DEPTH_S);

`ifdef CALC_RESBUF_CNT_EN
   always_ff @(posedge clk) begin
      if (srst) begin
         res_cnt_o <= '0;
      end else if (push) begin
         res_cnt_o <= res_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_calc_result_buf.sv
// Bench for calc_result_buf at DEPTH=4, Q_W=32; covers the push counter port
// when CALC_RESBUF_CNT_EN is defined.
module tb_calc_result_buf;

   localparam int DEPTH = 4;
   localparam int Q_W   = 32;

   logic          clk = 1'b0;
   logic          srst;
   logic          calc_tvalid;
   logic          res_tvalid;
   logic [Q_W-1:0] res_q;
   logic          issue_ok;
   logic          m_tvalid;
   logic [Q_W-1:0] m_tdata;
   logic          tready;
   logic [2:0]    level;
   logic          overflow;
`ifdef CALC_RESBUF_CNT_EN
   logic [31:0]   res_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   logic [Q_W-1:0] exp_q[$];
   int             m_infl = 0;
   bit             m_ov   = 1'b0;
   int             m_cnt  = 0;
   int             max_lvl;

   // clock / reset
   always #5 clk = ~clk;

   calc_result_buf #(
      .DEPTH (DEPTH),
      .Q_W   (Q_W)
   ) dut (
      .clk           (clk),
      .srst          (srst),
      .calc_tvalid_i (calc_tvalid),
      .res_tvalid_i  (res_tvalid),
      .res_q_i       (res_q),
      .issue_ok_o    (issue_ok),
      .m_tvalid_o    (m_tvalid),
      .m_tdata_o     (m_tdata),
      .m_tready_i    (tready),
      .level_o       (level),
      .overflow_o    (overflow)
`ifdef CALC_RESBUF_CNT_EN
      ,
      .res_cnt_o     (res_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_issue();
      return !srst && ((exp_q.size() + m_infl) < DEPTH);
   endfunction

   // reference model, evaluated on the same edge the DUT samples
   always @(posedge clk) begin
      if (srst) begin
         exp_q.delete();
         m_infl = 0;
         m_ov   = 1'b0;
         m_cnt  = 0;
      end else begin
         bit pop_m;
         bit acc_m;
         pop_m = (exp_q.size() != 0) && tready;
         acc_m = res_tvalid && ((exp_q.size() < DEPTH) || pop_m);
         if (pop_m) void'(exp_q.pop_front());
         if (acc_m) begin
            exp_q.push_back(res_q);
            m_cnt++;
         end else if (res_tvalid) begin
            m_ov = 1'b1;
         end
         if (calc_tvalid && !res_tvalid) m_infl++;
         else if (!calc_tvalid && res_tvalid && m_infl > 0) m_infl--;
      end
   end

   // scoreboard compare on the opposite edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("tvalid", 32'(m_tvalid), 32'(exp_q.size() != 0));
         check("level", 32'(level), 32'(exp_q.size()));
         check("overflow", 32'(overflow), 32'(m_ov));
         check("issue_ok", 32'(issue_ok), 32'(exp_issue()));
         if (exp_q.size() != 0) check("tdata", m_tdata, exp_q[0]);
      end
   end

   // driver: hold inputs for one clock, return 1 time unit after the edge
   task automatic step(input logic cv, input logic rv, input logic [Q_W-1:0] d);
      calc_tvalid = cv;
      res_tvalid  = rv;
      res_q       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
   endtask

   initial begin
      srst = 1'b1; calc_tvalid = 1'b0; res_tvalid = 1'b0; res_q = '0; tready = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      srst   = 1'b0;
      chk_en = 1'b1;
      #1;
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      check("rst_issue", 32'(issue_ok), 32'd1);

      // three results streaming through with downstream ready
      tready  = 1'b1;
      max_lvl = 0;
      step(1'b0, 1'b1, 32'h11);
      check("lat_11", m_tdata, 32'h11);
      check("lat_11_v", 32'(m_tvalid), 32'd1);
      if (level > max_lvl) max_lvl = level;
      step(1'b0, 1'b1, 32'h22);
      check("lat_22", m_tdata, 32'h22);
      if (level > max_lvl) max_lvl = level;
      step(1'b0, 1'b1, 32'h33);
      check("lat_33", m_tdata, 32'h33);
      if (level > max_lvl) max_lvl = level;
      check("max_level", 32'(max_lvl), 32'd1);
      idle(2);

      // fill through in-flight accounting, then overflow
      tready = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
      check("issue_blocked", 32'(issue_ok), 32'd0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'hA0 + 32'(i));
      check("full_level", 32'(level), 32'd4);
      step(1'b0, 1'b1, 32'h55);
      check("drop_ovf", 32'(overflow), 32'd1);
      check("drop_level", 32'(level), 32'd4);
      check("drop_head", m_tdata, 32'hA0);
      idle(3);
      check("ovf_sticky", 32'(overflow), 32'd1);

      // push and pop together while full
      tready = 1'b1;
      step(1'b0, 1'b1, 32'h66);
      check("full_pp_level", 32'(level), 32'd4);
      tready = 1'b0;
      idle(1);
      check("full_pp_head", m_tdata, 32'hA1);
      tready = 1'b1;
      idle(3);
      check("last_66", m_tdata, 32'h66);
      idle(1);
      check("drained", 32'(level), 32'd0);

      // stall with a known head
      tready = 1'b0;
      step(1'b0, 1'b1, 32'hDEADBEEF);
      step(1'b0, 1'b1, 32'h12345678);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("stall_data", m_tdata, 32'hDEADBEEF);
         check("stall_valid", 32'(m_tvalid), 32'd1);
      end
      tready = 1'b1;
      idle(3);

      // reset while holding three results and one in flight
      tready = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h31 + 32'(i));
      check("pre_rst_level", 32'(level), 32'd3);
      srst = 1'b1;
      #1;
      check("rst_issue_low", 32'(issue_ok), 32'd0);
      step(1'b1, 1'b1, 32'h99);
      srst = 1'b0;
      #1;
      check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_issue", 32'(issue_ok), 32'd1);
      check("mid_rst_ovf", 32'(overflow), 32'd0);
      calc_tvalid = 1'b0; res_tvalid = 1'b0;
      idle(1);

      // random traffic; upstream only issues when the model allows it
      for (int i = 0; i < 300; i++) begin
         logic cv;
         logic rv;
         tready = ($urandom_range(0, 3) != 0);
         cv = exp_issue() && ($urandom_range(0, 2) == 0);
         rv = ($urandom_range(0, 1) == 1);
         step(cv, rv, $urandom);
      end
      tready = 1'b1;
      idle(6);
      check("rand_drained", 32'(level), 32'd0);

`ifdef CALC_RESBUF_CNT_EN
      srst = 1'b1;
      idle(1);
      srst = 1'b0;
      check("cnt_rst", res_cnt, 32'd0);
      tready = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'h200 + 32'(i));
      step(1'b0, 1'b1, 32'h2FF);
      tready = 1'b1;
      idle(4);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h300 + 32'(i));
      idle(2);
      check("res_cnt", res_cnt, 32'd10);
`endif

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/calc_result_buf.md
CALC_RESULT_BUF -- requirements
Module: calc_result_buf

Interface
REQ-001 Parameter DEPTH, default 8: result FIFO entries; power of two, minimum 2.
REQ-002 Parameter Q_W, default Q_DWIDTH from calc_pkg: result data width.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port srst  input  1: reset, synchronous and active-high.
REQ-005 Port calc_tvalid_i  input  1: copy of the tvalid_i strobe the upstream issues into calc; one strobe is one result in flight.
REQ-006 Port res_tvalid_i  input  1: calc tvalid_o; qualifies res_q_i.
REQ-007 Port res_q_i  input  Q_W: calc q_o result.
REQ-008 Port issue_ok_o  output  1: upstream may strobe calc_tvalid_i this cycle.
REQ-009 Port m_tvalid_o  output  1: head result valid.
REQ-010 Port m_tdata_o  output  Q_W: head result data.
REQ-011 Port m_tready_i  input  1: downstream accepts the head.
REQ-012 Port level_o  output  $clog2(DEPTH)+1: stored entry count.
REQ-013 Port overflow_o  output  1: sticky; a result was dropped.

Function
REQ-014 Push SHALL occur when res_tvalid_i=1 and (level<DEPTH or a pop occurs in the same cycle).
REQ-015 A result arriving while full with no same-cycle pop SHALL be dropped, leave contents unchanged and set overflow_o the next cycle.
REQ-016 Pop SHALL occur when m_tvalid_o=1 and m_tready_i=1.
REQ-017 m_tvalid_o SHALL equal (level_o!=0); m_tdata_o SHALL be the oldest entry, show-ahead, and SHALL stay stable while m_tvalid_o=1 and m_tready_i=0.
REQ-018 Push-to-m_tvalid_o latency SHALL be 1 cycle; there is no combinational bypass from res_q_i.
REQ-019 Simultaneous push and pop SHALL leave level unchanged, including at full and at level 1.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 In-flight counter: +1 on calc_tvalid_i, -1 on res_tvalid_i, unchanged if both or neither; a decrement at 0 SHALL hold it at 0.
REQ-022 issue_ok_o SHALL be combinational from registered state: (level + inflight) < DEPTH, forced 0 while srst=1.
REQ-023 Results SHALL leave in arrival order; values pass through unmodified, with no sign handling.

Reset
REQ-024 With srst=1 at a clock edge: pointers, level_o, inflight and overflow_o SHALL become 0; m_tvalid_o SHALL be 0 the following cycle.
REQ-025 Reset mid-operation SHALL discard stored and in-flight results; FIFO RAM contents need not clear.
REQ-026 Inputs SHALL be ignored during the srst cycle.

Configuration
REQ-027 Macro CALC_RESBUF_CNT_EN defined: add output res_cnt_o (32 bits), counting accepted pushes, wrapping at 2^32, reset to 0.
REQ-028 Macro CALC_RESBUF_CNT_EN undefined: port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-029 calc_pkg SHALL hold Q_DWIDTH and a new RESBUF_DEPTH default constant.
REQ-030 Storage SHALL be the sub-module calc_resbuf_fifo: synchronous, show-ahead, parameterised by width and depth.
REQ-031 Flow control (inflight, issue_ok, overflow, optional counter) SHALL stay in calc_result_buf.

Verification (DEPTH=4, Q_W=32)
REQ-032 Reset, then 3 results 0x11, 0x22, 0x33 with m_tready_i=1 -> each appears one cycle after arrival, in order; level_o never exceeds 1.
REQ-033 m_tready_i=0, 4 calc_tvalid_i strobes -> issue_ok_o=0 after the 4th; a 5th result 0x55 -> dropped, overflow_o=1 and stays 1; level_o=4.
REQ-034 Full, m_tready_i=1 plus simultaneous push 0x66 -> level_o stays 4; 0x66 emerges last.
REQ-035 Stall m_tready_i=0 for 5 cycles with head 0xDEADBEEF -> m_tdata_o and m_tvalid_o constant.
REQ-036 srst during level=3 and inflight=1 -> next cycle m_tvalid_o=0, level_o=0, issue_ok_o=1, overflow_o=0.
REQ-037 CALC_RESBUF_CNT_EN defined, 10 accepted results plus 1 dropped -> res_cnt_o=10.
